// File: rtl/vc_input_buffer_pkg.sv
// Shared constants for the router input buffer: flit/VC widths, default VC depth, VC count.
// Optional feature macro used by the top level: VCBUF_CREDIT_EN (per-VC credit return pulses).
package vc_input_buffer_pkg;

`ifndef DATAW
`define DATAW 7
`endif
`ifndef VCHW
`define VCHW 0
`endif
`ifndef PORT
`define PORT 5
`endif
`ifndef VCBUF_DEPTH
`define VCBUF_DEPTH 4
`endif
`ifndef NVC
`define NVC 2
`endif

    localparam int FLIT_W    = `DATAW + 1;
    localparam int VCH_W     = `VCHW + 1;
    localparam int NUM_PORTS = `PORT;
    localparam int NUM_VC    = `NVC;
    localparam int DEF_DEPTH = `VCBUF_DEPTH;

endpackage

// File: rtl/vc_input_buffer_fifo.sv
// vc_fifo: single-clock FIFO for one virtual channel with combinational head read.
// A pop on empty is ignored; a push on full is only accepted when a pop frees a slot.
module vc_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    output logic             o_full,
    output logic             o_pop_ok
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             r_full;
    logic [CW-1:0]    w_count_next;
    logic             w_pop;
    logic             w_push;

    assign w_pop  = i_pop && (r_count != '0);
    assign w_push = i_push && (!r_full || w_pop);

    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + 1'b1;
            2'b01:   w_count_next = r_count - 1'b1;
            default: w_count_next = r_count;
        endcase
    end

    // Storage is cleared on reset so the head outputs read zero afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= w_count_next;
            r_full  <= (w_count_next == FULL_CNT);
        end
    end

    assign o_data   = r_mem[r_rd_ptr];
    assign o_valid  = (r_count != '0);
    assign o_full   = r_full;
    assign o_pop_ok = w_pop;

endmodule

// File: rtl/vc_input_buffer.sv
// Router input port buffer: steers link flits into per-VC FIFOs, exposes heads, flags overflow.
// Define VCBUF_CREDIT_EN to generate per-VC credit pulses; otherwise ocredit is tied low.
module vc_input_buffer
    import vc_input_buffer_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int NVC   = NUM_VC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [FLIT_W-1:0] idata,
    input  logic              ivalid,
    input  logic [VCH_W-1:0]  ivch,
    input  logic [1:0]        ipop,
    output logic [FLIT_W-1:0] odata_0,
    output logic [FLIT_W-1:0] odata_1,
    output logic              ovalid_0,
    output logic              ovalid_1,
    output logic [1:0]        ofull,
    output logic [1:0]        ocredit,
    output logic              oerr
);
    logic [FLIT_W-1:0] w_head [NVC];
    logic [NVC-1:0]    w_push;
    logic [NVC-1:0]    w_valid;
    logic [NVC-1:0]    w_full;
    logic [NVC-1:0]    w_pop_ok;
    logic [NVC-1:0]    w_drop;
    logic              r_err;

    genvar gi;
    generate
        for (gi = 0; gi < NVC; gi++) begin : g_vc
            assign w_push[gi] = ivalid && (ivch == VCH_W'(gi));
            // A push to a full VC is lost unless the same edge pops that VC.
            assign w_drop[gi] = w_push[gi] && w_full[gi] && !w_pop_ok[gi];

            vc_fifo #(
                .DEPTH (DEPTH),
                .WIDTH (FLIT_W)
            ) u_fifo (
                .clk      (clk),
                .rst      (rst),
                .i_push   (w_push[gi]),
                .i_pop    (ipop[gi]),
                .i_data   (idata),
                .o_data   (w_head[gi]),
                .o_valid  (w_valid[gi]),
                .o_full   (w_full[gi]),
                .o_pop_ok (w_pop_ok[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (|w_drop) begin
            r_err <= 1'b1;
        end
    end

`ifdef VCBUF_CREDIT_EN
    logic [NVC-1:0] r_credit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_credit <= '0;
        end else begin
            r_credit <= w_pop_ok;
        end
    end

    assign ocredit = r_credit;
`else
    assign ocredit = 2'b00;
`endif

    assign odata_0  = w_head[0];
    assign odata_1  = w_head[1];
    assign ovalid_0 = w_valid[0];
    assign ovalid_1 = w_valid[1];
    assign ofull    = w_full;
    assign oerr     = r_err;

endmodule

// File: tb/tb_vc_input_buffer.sv
// Self-checking bench for vc_input_buffer: directed scenarios plus random traffic
// compared against a queue-based model of the per-VC buffers.
module tb_vc_input_buffer;
    import vc_input_buffer_pkg::*;

    localparam int DEPTH = 4;
`ifdef VCBUF_CREDIT_EN
    localparam bit CREDIT_EN = 1'b1;
`else
    localparam bit CREDIT_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic [FLIT_W-1:0] idata;
    logic              ivalid;
    logic [VCH_W-1:0]  ivch;
    logic [1:0]        ipop;
    logic [FLIT_W-1:0] odata_0;
    logic [FLIT_W-1:0] odata_1;
    logic              ovalid_0;
    logic              ovalid_1;
    logic [1:0]        ofull;
    logic [1:0]        ocredit;
    logic              oerr;

    int checks   = 0;
    int failures = 0;
    int txn      = 0;

    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic       m_err;
    logic [1:0] m_credit;

    vc_input_buffer #(.DEPTH(DEPTH), .NVC(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .idata    (idata),
        .ivalid   (ivalid),
        .ivch     (ivch),
        .ipop     (ipop),
        .odata_0  (odata_0),
        .odata_1  (odata_1),
        .ovalid_0 (ovalid_0),
        .ovalid_1 (ovalid_1),
        .ofull    (ofull),
        .ocredit  (ocredit),
        .oerr     (oerr)
    );

    always #5 clk = ~clk;

    // Drive one cycle of stimulus, update the model at the edge, return 1 time unit after it.
    task automatic step(input bit v, input bit vc, input logic [7:0] d, input logic [1:0] p);
        logic [1:0] popok;
        @(negedge clk);
        ivalid = v;
        ivch   = vc;
        idata  = d;
        ipop   = p;
        @(posedge clk);
        popok[0] = p[0] && (q0.size() > 0);
        popok[1] = p[1] && (q1.size() > 0);
        if (popok[0]) void'(q0.pop_front());
        if (popok[1]) void'(q1.pop_front());
        if (v) begin
            if (vc == 1'b0) begin
                if (q0.size() < DEPTH) q0.push_back(d);
                else m_err = 1'b1;
            end else begin
                if (q1.size() < DEPTH) q1.push_back(d);
                else m_err = 1'b1;
            end
        end
        m_credit = CREDIT_EN ? popok : 2'b00;
        #1;
        ivalid = 1'b0;
        ipop   = 2'b00;
        txn++;
        $display("txn %0d: valid=%0b vc=%0d data=%02h pop=%02b -> size0=%0d size1=%0d",
                 txn, v, vc, d, p, q0.size(), q1.size());
    endtask

    task automatic test_reset();
        rst = 1'b1; ivalid = 1'b0; ivch = '0; idata = '0; ipop = 2'b00;
        q0.delete(); q1.delete(); m_err = 1'b0; m_credit = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({ovalid_1, ovalid_0} !== 2'b00) begin failures++; $display("FAIL reset_ovalid got=%02b exp=00", {ovalid_1, ovalid_0}); end
        checks++;
        if ({odata_1, odata_0} !== 16'h0000) begin failures++; $display("FAIL reset_odata got=%04h exp=0000", {odata_1, odata_0}); end
        checks++;
        if ({ofull, ocredit, oerr} !== 5'b0) begin failures++; $display("FAIL reset_flags got=%05b exp=00000", {ofull, ocredit, oerr}); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_push_visible();
        step(1'b1, 1'b1, 8'h10, 2'b00);
        checks++;
        if (ovalid_1 !== 1'b1 || odata_1 !== 8'h10) begin failures++; $display("FAIL push_vc1 got valid=%0b data=%02h exp valid=1 data=10", ovalid_1, odata_1); end
        checks++;
        if (ovalid_0 !== 1'b0) begin failures++; $display("FAIL push_vc1_other got ovalid_0=%0b exp=0", ovalid_0); end
    endtask

    task automatic test_overflow();
        logic [7:0] vals [4];
        vals[0] = 8'h21; vals[1] = 8'h32; vals[2] = 8'h43; vals[3] = 8'h54;
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, vals[i], 2'b00);
        checks++;
        if (ofull !== 2'b01 || oerr !== 1'b0) begin failures++; $display("FAIL fill_vc0 got ofull=%02b oerr=%0b exp ofull=01 oerr=0", ofull, oerr); end
        step(1'b1, 1'b0, 8'h65, 2'b00);
        checks++;
        if (oerr !== m_err || oerr !== 1'b1) begin failures++; $display("FAIL overflow_err got=%0b exp=1", oerr); end
        checks++;
        if (odata_0 !== 8'h21 || ofull !== 2'b01) begin failures++; $display("FAIL overflow_head got data=%02h ofull=%02b exp data=21 ofull=01", odata_0, ofull); end
    endtask

    task automatic test_full_push_pop();
        logic [7:0] exp_d;
        step(1'b1, 1'b0, 8'h77, 2'b01);
        checks++;
        if (ofull[0] !== 1'b1 || odata_0 !== 8'h32) begin failures++; $display("FAIL full_pushpop got ofull0=%0b head=%02h exp ofull0=1 head=32", ofull[0], odata_0); end
        checks++;
        if (ocredit !== m_credit) begin failures++; $display("FAIL full_pushpop_credit got=%02b exp=%02b", ocredit, m_credit); end
        while (q0.size() > 0) begin
            exp_d = q0[0];
            checks++;
            if (ovalid_0 !== 1'b1 || odata_0 !== exp_d) begin failures++; $display("FAIL drain_vc0 got valid=%0b data=%02h exp valid=1 data=%02h", ovalid_0, odata_0, exp_d); end
            step(1'b0, 1'b0, 8'h00, 2'b01);
            checks++;
            if (ocredit !== m_credit) begin failures++; $display("FAIL drain_vc0_credit got=%02b exp=%02b", ocredit, m_credit); end
        end
        checks++;
        if (ovalid_0 !== 1'b0 || ofull !== 2'b00) begin failures++; $display("FAIL drain_vc0_empty got valid=%0b ofull=%02b exp valid=0 ofull=00", ovalid_0, ofull); end
        step(1'b0, 1'b0, 8'h00, 2'b10);
    endtask

    task automatic test_dual_pop();
        step(1'b1, 1'b0, 8'hA0, 2'b00);
        step(1'b1, 1'b1, 8'hB1, 2'b00);
        checks++;
        if (odata_0 !== 8'hA0 || odata_1 !== 8'hB1) begin failures++; $display("FAIL dual_heads got %02h %02h exp A0 B1", odata_0, odata_1); end
        step(1'b0, 1'b0, 8'h00, 2'b11);
        checks++;
        if (ocredit !== (CREDIT_EN ? 2'b11 : 2'b00)) begin failures++; $display("FAIL dual_credit got=%02b exp=%02b", ocredit, CREDIT_EN ? 2'b11 : 2'b00); end
        checks++;
        if ({ovalid_1, ovalid_0} !== 2'b00) begin failures++; $display("FAIL dual_empty got=%02b exp=00", {ovalid_1, ovalid_0}); end
        step(1'b0, 1'b0, 8'h00, 2'b00);
        checks++;
        if (ocredit !== 2'b00) begin failures++; $display("FAIL dual_credit_width got=%02b exp=00", ocredit); end
    endtask

    task automatic test_empty_pop();
        logic err_before;
        err_before = oerr;
        step(1'b0, 1'b0, 8'h00, 2'b10);
        checks++;
        if (ocredit !== 2'b00 || ovalid_1 !== 1'b0 || oerr !== err_before) begin failures++; $display("FAIL empty_pop got credit=%02b valid1=%0b oerr=%0b exp 00 0 %0b", ocredit, ovalid_1, oerr, err_before); end
        step(1'b1, 1'b0, 8'h5C, 2'b01);
        checks++;
        if (ovalid_0 !== 1'b1 || odata_0 !== 8'h5C || ocredit !== 2'b00) begin failures++; $display("FAIL empty_pushpop got valid=%0b data=%02h credit=%02b exp 1 5C 00", ovalid_0, odata_0, ocredit); end
    endtask

    task automatic test_reset_mid();
        step(1'b1, 1'b1, 8'hC3, 2'b00);
        step(1'b1, 1'b0, 8'hD4, 2'b01);
        rst = 1'b1;
        #1;
        checks++;
        if ({ovalid_1, ovalid_0, ofull, ocredit, oerr} !== 7'b0) begin failures++; $display("FAIL midreset_flags got=%07b exp=0000000", {ovalid_1, ovalid_0, ofull, ocredit, oerr}); end
        checks++;
        if ({odata_1, odata_0} !== 16'h0000) begin failures++; $display("FAIL midreset_data got=%04h exp=0000", {odata_1, odata_0}); end
        q0.delete(); q1.delete(); m_err = 1'b0; m_credit = 2'b00;
        @(negedge clk);
        rst = 1'b0;
        step(1'b1, 1'b0, 8'hE5, 2'b00);
        checks++;
        if (ovalid_0 !== 1'b1 || odata_0 !== 8'hE5 || ocredit !== 2'b00) begin failures++; $display("FAIL postreset_push got valid=%0b data=%02h credit=%02b exp 1 E5 00", ovalid_0, odata_0, ocredit); end
    endtask

    task automatic test_random();
        bit         v;
        bit         vc;
        logic [7:0] d;
        logic [1:0] p;
        logic [1:0] exp_full;
        for (int n = 0; n < 300; n++) begin
            v    = ($urandom_range(0, 9) < 7);
            vc   = 1'($urandom_range(0, 1));
            d    = 8'($urandom);
            p[0] = ($urandom_range(0, 99) < 35);
            p[1] = ($urandom_range(0, 99) < 35);
            step(v, vc, d, p);
            exp_full = {q1.size() == DEPTH, q0.size() == DEPTH};
            checks++;
            if (ovalid_0 !== (q0.size() > 0) || ovalid_1 !== (q1.size() > 0)) begin failures++; $display("FAIL rand_valid n=%0d got=%0b%0b exp=%0b%0b", n, ovalid_1, ovalid_0, q1.size() > 0, q0.size() > 0); end
            if (q0.size() > 0) begin
                checks++;
                if (odata_0 !== q0[0]) begin failures++; $display("FAIL rand_head0 n=%0d got=%02h exp=%02h", n, odata_0, q0[0]); end
            end
            if (q1.size() > 0) begin
                checks++;
                if (odata_1 !== q1[0]) begin failures++; $display("FAIL rand_head1 n=%0d got=%02h exp=%02h", n, odata_1, q1[0]); end
            end
            checks++;
            if (ofull !== exp_full || ocredit !== m_credit || oerr !== m_err) begin failures++; $display("FAIL rand_flags n=%0d got full=%02b credit=%02b err=%0b exp full=%02b credit=%02b err=%0b", n, ofull, ocredit, oerr, exp_full, m_credit, m_err); end
        end
    endtask

    initial begin
        test_reset();
        test_push_visible();
        test_overflow();
        test_full_push_pop();
        test_dual_pop();
        test_empty_pop();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
